// File: rtl/maze_episode_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maze_episode_controller: grid-maze episode sequencer for a Q-learning agent |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module maze_episode_controller #(
  parameter int GRID_W       = 5,
  parameter int GRID_H       = 5,
  parameter int STATE_W      = 6,
  parameter int REWARD_W     = 16,
  parameter int MAX_STEPS    = 64,
  parameter int CNT_W        = 16,
  parameter int GOAL_REWARD  = 100,
  parameter int HIT_PENALTY  = -100,
  parameter int STEP_PENALTY = -1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       start,
  input  logic [STATE_W-1:0]         start_state,
  input  logic [STATE_W-1:0]         goal_state,
  input  logic [GRID_W*GRID_H-1:0]   obstacle_mask,
  input  logic                       act_valid,
  output logic                       act_ready,
  input  logic [1:0]                 action,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [STATE_W-1:0]         cur_state,
  output logic [STATE_W-1:0]         next_state,
  output logic [REWARD_W-1:0]        reward,
  output logic                       terminal,
  output logic                       busy,
  output logic                       goal,
  output logic                       error,
  output logic                       timeout,
  output logic                       config_err,
  output logic [CNT_W-1:0]           step_cnt,
  output logic [CNT_W-1:0]           episode_cnt
);

  localparam int                  c_cells     = GRID_W * GRID_H;
  localparam logic [c_cells-1:0]  c_lsb       = c_cells'(1);
  localparam logic [STATE_W-1:0]  c_grid_w    = STATE_W'(GRID_W);
  localparam logic [STATE_W-1:0]  c_last_col  = STATE_W'(GRID_W - 1);
  localparam logic [STATE_W-1:0]  c_last_row  = STATE_W'(GRID_H - 1);
  localparam logic [STATE_W-1:0]  c_one_st    = STATE_W'(1);
  localparam logic [CNT_W-1:0]    c_one_cnt   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    c_max_steps = CNT_W'(MAX_STEPS);
  localparam logic [REWARD_W-1:0] c_rw_goal   = REWARD_W'(GOAL_REWARD);
  localparam logic [REWARD_W-1:0] c_rw_hit    = REWARD_W'(HIT_PENALTY);
  localparam logic [REWARD_W-1:0] c_rw_step   = REWARD_W'(STEP_PENALTY);

  localparam logic [1:0] c_kind_none    = 2'd0;
  localparam logic [1:0] c_kind_goal    = 2'd1;
  localparam logic [1:0] c_kind_error   = 2'd2;
  localparam logic [1:0] c_kind_timeout = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACT = 2'd1,
    UPDATE   = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [STATE_W-1:0]    r_cur;
  logic [STATE_W-1:0]    r_next;
  logic [REWARD_W-1:0]   r_reward;
  logic                  r_terminal;
  logic [1:0]            r_kind;
  logic                  r_goal;
  logic                  r_error;
  logic                  r_timeout;
  logic                  r_cfg_err;
  logic [CNT_W-1:0]      r_step;
  logic [CNT_W-1:0]      r_epi;

  logic                  w_start_bad;
  logic                  w_start_ok;
  logic                  w_reject;
  logic                  w_act_fire;
  logic                  w_upd_fire;
  logic [STATE_W-1:0]    w_row;
  logic [STATE_W-1:0]    w_col;
  logic [STATE_W-1:0]    w_nxt;
  logic                  w_nxt_obs;
  logic [REWARD_W-1:0]   w_reward;
  logic                  w_terminal;
  logic [1:0]            w_kind;

  assign w_start_bad = (32'(start_state) >= c_cells) ||
                       (|(obstacle_mask & (c_lsb << start_state)));

  // Moves off the grid edge leave the agent where it is.
  always_comb begin
    w_row = r_cur / c_grid_w;
    w_col = r_cur % c_grid_w;
    w_nxt = r_cur;
    case (action)
      2'd0:    if (w_row != '0)         w_nxt = r_cur - c_grid_w;
      2'd1:    if (w_col != c_last_col) w_nxt = r_cur + c_one_st;
      2'd2:    if (w_row != c_last_row) w_nxt = r_cur + c_grid_w;
      default: if (w_col != '0)         w_nxt = r_cur - c_one_st;
    endcase
  end

  assign w_nxt_obs = |(obstacle_mask & (c_lsb << w_nxt));

  always_comb begin
    w_reward   = c_rw_step;
    w_terminal = 1'b0;
    w_kind     = c_kind_none;
    if (w_nxt == goal_state) begin
      w_reward   = c_rw_goal;
      w_terminal = 1'b1;
      w_kind     = c_kind_goal;
    end else if (w_nxt_obs) begin
      w_reward   = c_rw_hit;
      w_terminal = 1'b1;
      w_kind     = c_kind_error;
    end else if ((r_step + c_one_cnt) == c_max_steps) begin
      w_terminal = 1'b1;
      w_kind     = c_kind_timeout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_reject    = 1'b0;
    w_act_fire  = 1'b0;
    w_upd_fire  = 1'b0;
    act_ready   = 1'b0;
    upd_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      WAIT_ACT: begin
        busy      = 1'b1;
        act_ready = en;
        if (en && act_valid) begin
          w_act_fire  = 1'b1;
          w_state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        busy      = 1'b1;
        upd_valid = 1'b1;
        if (en && upd_ready) begin
          w_upd_fire  = 1'b1;
          w_state_nxt = r_terminal ? DONE : WAIT_ACT;
        end
      end
      default: begin
        if (en && start) begin
          if (w_start_bad) begin
            w_reject = 1'b1;
          end else begin
            w_start_ok  = 1'b1;
            w_state_nxt = WAIT_ACT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_next     <= '0;
      r_reward   <= '0;
      r_terminal <= 1'b0;
      r_kind     <= c_kind_none;
      r_goal     <= 1'b0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_step     <= '0;
      r_epi      <= '0;
    end else if (en) begin
      r_cfg_err <= w_reject;
      if (w_start_ok) begin
        r_cur     <= start_state;
        r_step    <= '0;
        r_goal    <= 1'b0;
        r_error   <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_act_fire) begin
        r_next     <= w_nxt;
        r_reward   <= w_reward;
        r_terminal <= w_terminal;
        r_kind     <= w_kind;
      end
      if (w_upd_fire) begin
        r_cur  <= r_next;
        r_step <= r_step + c_one_cnt;
        if (r_terminal) begin
          r_goal    <= r_goal    | (r_kind == c_kind_goal);
          r_error   <= r_error   | (r_kind == c_kind_error);
          r_timeout <= r_timeout | (r_kind == c_kind_timeout);
          if (r_epi != '1) r_epi <= r_epi + c_one_cnt;
        end
      end
    end
  end

  assign cur_state   = r_cur;
  assign next_state  = r_next;
  assign reward      = r_reward;
  assign terminal    = r_terminal;
  assign goal        = r_goal;
  assign error       = r_error;
  assign timeout     = r_timeout;
  assign config_err  = r_cfg_err;
  assign step_cnt    = r_step;
  assign episode_cnt = r_epi;

endmodule
`default_nettype wire

// File: tb/tb_maze_episode_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_maze_episode_controller: randomized and directed bench with grid model   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_maze_episode_controller;

  localparam int GW = 5;
  localparam int GH = 5;
  localparam int NC = GW * GH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  start_state = '0;
  logic [5:0]  goal_state = '0;
  logic [24:0] obstacle_mask = '0;
  logic        act_valid = 1'b0;
  logic [1:0]  action = '0;
  logic        upd_ready = 1'b0;

  // d_* : default instance (MAX_STEPS=64), t_* : short instance (MAX_STEPS=4)
  logic        d_act_ready, d_upd_valid, d_terminal, d_busy, d_goal, d_error, d_timeout, d_cfg;
  logic [5:0]  d_cur, d_next;
  logic [15:0] d_reward, d_step, d_epi;
  logic        t_act_ready, t_upd_valid, t_terminal, t_busy, t_goal, t_error, t_timeout, t_cfg;
  logic [5:0]  t_cur, t_next;
  logic [15:0] t_reward, t_step, t_epi;

  maze_episode_controller u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .start_state(start_state),
    .goal_state(goal_state), .obstacle_mask(obstacle_mask), .act_valid(act_valid),
    .act_ready(d_act_ready), .action(action), .upd_valid(d_upd_valid), .upd_ready(upd_ready),
    .cur_state(d_cur), .next_state(d_next), .reward(d_reward), .terminal(d_terminal),
    .busy(d_busy), .goal(d_goal), .error(d_error), .timeout(d_timeout), .config_err(d_cfg),
    .step_cnt(d_step), .episode_cnt(d_epi)
  );

  maze_episode_controller #(.MAX_STEPS(4)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .start_state(start_state),
    .goal_state(goal_state), .obstacle_mask(obstacle_mask), .act_valid(act_valid),
    .act_ready(t_act_ready), .action(action), .upd_valid(t_upd_valid), .upd_ready(upd_ready),
    .cur_state(t_cur), .next_state(t_next), .reward(t_reward), .terminal(t_terminal),
    .busy(t_busy), .goal(t_goal), .error(t_error), .timeout(t_timeout), .config_err(t_cfg),
    .step_cnt(t_step), .episode_cnt(t_epi)
  );

  always #5 clk = ~clk;

  logic        use_t = 1'b0;
  logic        m_act_ready, m_upd_valid, m_terminal, m_busy, m_goal, m_error, m_timeout, m_cfg;
  logic [5:0]  m_cur_o, m_next_o;
  logic [15:0] m_reward_o, m_step_o, m_epi_o;

  assign m_act_ready = use_t ? t_act_ready : d_act_ready;
  assign m_upd_valid = use_t ? t_upd_valid : d_upd_valid;
  assign m_terminal  = use_t ? t_terminal  : d_terminal;
  assign m_busy      = use_t ? t_busy      : d_busy;
  assign m_goal      = use_t ? t_goal      : d_goal;
  assign m_error     = use_t ? t_error     : d_error;
  assign m_timeout   = use_t ? t_timeout   : d_timeout;
  assign m_cfg       = use_t ? t_cfg       : d_cfg;
  assign m_cur_o     = use_t ? t_cur       : d_cur;
  assign m_next_o    = use_t ? t_next      : d_next;
  assign m_reward_o  = use_t ? t_reward    : d_reward;
  assign m_step_o    = use_t ? t_step      : d_step;
  assign m_epi_o     = use_t ? t_epi       : d_epi;

  int checks = 0;
  int failures = 0;

  // Behavioural episode model
  int ex_cur, ex_step, ex_epi;
  bit ex_goal, ex_err, ex_to, ex_busy;

  function automatic int ref_next(int cur, int a);
    int r = cur / GW;
    int c = cur % GW;
    case (a)
      0:       return (r == 0)      ? cur : cur - GW;
      1:       return (c == GW - 1) ? cur : cur + 1;
      2:       return (r == GH - 1) ? cur : cur + GW;
      default: return (c == 0)      ? cur : cur - 1;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; start = 1'b0; act_valid = 1'b0; upd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ex_cur = 0; ex_step = 0; ex_epi = 0;
    ex_goal = 0; ex_err = 0; ex_to = 0; ex_busy = 0;
  endtask

  task automatic do_start(input int s);
    bit bad = (s >= NC) ? 1'b1 : obstacle_mask[s];
    start = 1'b1; start_state = 6'(s);
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (bad) begin
      if (m_cfg !== 1'b1 || m_busy !== ex_busy) begin
        failures++;
        $display("FAIL start_reject s=%0d: config_err=%b busy=%b, need 1 %b", s, m_cfg, m_busy, ex_busy);
      end
      @(posedge clk); #1;
      checks++;
      if (m_cfg !== 1'b0) begin
        failures++;
        $display("FAIL config_err_pulse s=%0d: config_err=%b, need 0", s, m_cfg);
      end
    end else begin
      ex_cur = s; ex_step = 0; ex_goal = 0; ex_err = 0; ex_to = 0; ex_busy = 1;
      if (m_busy !== 1'b1 || m_act_ready !== 1'b1 || m_cur_o !== 6'(s) || m_step_o !== 16'd0 ||
          m_cfg !== 1'b0 || {m_goal, m_error, m_timeout} !== 3'b000) begin
        failures++;
        $display("FAIL start_accept s=%0d: busy=%b ready=%b cur=%0d step=%0d cfg=%b flags=%b%b%b, need 1 1 %0d 0 0 000",
                 s, m_busy, m_act_ready, m_cur_o, m_step_o, m_cfg, m_goal, m_error, m_timeout, s);
      end
    end
  endtask

  task automatic do_step(input int a, input int dly, output bit term);
    int max_steps = use_t ? 4 : 64;
    int nxt = ref_next(ex_cur, a);
    int rw;
    int n = 0;
    int kind = 0;
    logic [5:0]  h_next;
    logic [15:0] h_rw;
    if (nxt == int'(goal_state))     begin rw = 100;  kind = 1; end
    else if (obstacle_mask[nxt])     begin rw = -100; kind = 2; end
    else if (ex_step + 1 == max_steps) begin rw = -1; kind = 3; end
    else                             begin rw = -1;   kind = 0; end
    term = (kind != 0);
    act_valid = 1'b1; action = 2'(a);
    while (m_act_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1 n++;
    end
    if (n == 20) begin
      act_valid = 1'b0;
      checks++; failures++;
      $display("FAIL act_ready_timeout: act_ready=%b, need 1 within 20 cycles", m_act_ready);
      return;
    end
    @(posedge clk); #1 act_valid = 1'b0;
    checks++;
    if (m_upd_valid !== 1'b1 || m_act_ready !== 1'b0 || m_next_o !== 6'(nxt) ||
        m_reward_o !== 16'(rw) || m_terminal !== term) begin
      failures++;
      $display("FAIL update_payload cur=%0d a=%0d: valid=%b ready=%b next=%0d rw=%0d term=%b, need 1 0 %0d %0d %b",
               ex_cur, a, m_upd_valid, m_act_ready, m_next_o, $signed(m_reward_o), m_terminal, nxt, rw, term);
    end
    h_next = m_next_o; h_rw = m_reward_o;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m_upd_valid !== 1'b1 || m_next_o !== h_next || m_reward_o !== h_rw || m_terminal !== term) begin
        failures++;
        $display("FAIL backpressure_hold: valid=%b next=%0d rw=%0d term=%b, need 1 %0d %0d %b",
                 m_upd_valid, m_next_o, $signed(m_reward_o), m_terminal, h_next, $signed(h_rw), term);
      end
    end
    upd_ready = 1'b1;
    @(posedge clk); #1 upd_ready = 1'b0;
    ex_cur = nxt; ex_step++;
    if (term) begin
      ex_busy = 0;
      if (ex_epi < 65535) ex_epi++;
      if (kind == 1) ex_goal = 1;
      if (kind == 2) ex_err = 1;
      if (kind == 3) ex_to = 1;
    end
    checks++;
    if (m_upd_valid !== 1'b0 || m_cur_o !== 6'(ex_cur) || m_step_o !== 16'(ex_step) ||
        m_busy !== ex_busy || m_act_ready !== ex_busy || m_epi_o !== 16'(ex_epi) ||
        {m_goal, m_error, m_timeout} !== {ex_goal, ex_err, ex_to}) begin
      failures++;
      $display("FAIL after_transfer: valid=%b cur=%0d step=%0d busy=%b ready=%b epi=%0d flags=%b%b%b, need 0 %0d %0d %b %b %0d %b%b%b",
               m_upd_valid, m_cur_o, m_step_o, m_busy, m_act_ready, m_epi_o, m_goal, m_error, m_timeout,
               ex_cur, ex_step, ex_busy, ex_busy, ex_epi, ex_goal, ex_err, ex_to);
    end
  endtask

  task automatic test_reset();
    use_t = 1'b0;
    do_reset();
    checks++;
    if ({m_act_ready, m_upd_valid, m_terminal, m_busy, m_goal, m_error, m_timeout, m_cfg} !== 8'h00 ||
        m_cur_o !== 6'd0 || m_next_o !== 6'd0 || m_reward_o !== 16'd0 || m_step_o !== 16'd0 || m_epi_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_values: bits=%b cur=%0d next=%0d rw=%0d step=%0d epi=%0d, need all 0",
               {m_act_ready, m_upd_valid, m_terminal, m_busy, m_goal, m_error, m_timeout, m_cfg},
               m_cur_o, m_next_o, m_reward_o, m_step_o, m_epi_o);
    end
  endtask

  task automatic test_goal_path();
    bit t;
    use_t = 1'b0;
    do_reset();
    obstacle_mask = '0; obstacle_mask[7] = 1'b1; obstacle_mask[13] = 1'b1;
    goal_state = 6'd24;
    do_start(0);
    for (int i = 0; i < 4; i++) do_step(2, 0, t);
    for (int i = 0; i < 4; i++) do_step(1, i % 2, t);
    checks++;
    if (m_goal !== 1'b1 || m_error !== 1'b0 || m_step_o !== 16'd8 || m_epi_o !== 16'd1 || m_busy !== 1'b0 || t !== 1'b1) begin
      failures++;
      $display("FAIL goal_path_end: goal=%b err=%b step=%0d epi=%0d busy=%b term=%b, need 1 0 8 1 0 1",
               m_goal, m_error, m_step_o, m_epi_o, m_busy, t);
    end
  endtask

  task automatic test_wall_and_obstacle();
    bit t;
    use_t = 1'b0;
    do_reset();
    obstacle_mask = '0; obstacle_mask[7] = 1'b1; obstacle_mask[13] = 1'b1;
    goal_state = 6'd24;
    do_start(0);
    do_step(0, 0, t);
    do_step(3, 0, t);
    checks++;
    if (m_cur_o !== 6'd0 || t !== 1'b0) begin
      failures++;
      $display("FAIL wall_bump: cur=%0d term=%b, need 0 0", m_cur_o, t);
    end
    do_reset();
    do_start(2);
    do_step(2, 1, t);
    checks++;
    if (m_error !== 1'b1 || m_goal !== 1'b0 || m_cur_o !== 6'd7) begin
      failures++;
      $display("FAIL obstacle_hit: err=%b goal=%b cur=%0d, need 1 0 7", m_error, m_goal, m_cur_o);
    end
    // Goal on a masked cell still counts as goal.
    goal_state = 6'd7;
    do_start(6);
    do_step(1, 0, t);
    checks++;
    if (m_goal !== 1'b1 || m_error !== 1'b0 || m_epi_o !== 16'd2) begin
      failures++;
      $display("FAIL masked_goal: goal=%b err=%b epi=%0d, need 1 0 2", m_goal, m_error, m_epi_o);
    end
  endtask

  task automatic test_timeout();
    bit t;
    use_t = 1'b1;
    do_reset();
    obstacle_mask = '0; obstacle_mask[7] = 1'b1; obstacle_mask[13] = 1'b1;
    goal_state = 6'd24;
    do_start(0);
    for (int i = 0; i < 4; i++) begin
      do_step(3, 0, t);
      checks++;
      if (t !== (i == 3)) begin
        failures++;
        $display("FAIL timeout_step%0d: term=%b, need %b", i, t, (i == 3));
      end
    end
    checks++;
    if (m_timeout !== 1'b1 || m_step_o !== 16'd4 || m_busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_end: timeout=%b step=%0d busy=%b, need 1 4 0", m_timeout, m_step_o, m_busy);
    end
    use_t = 1'b0;
  endtask

  task automatic test_enable();
    bit t;
    use_t = 1'b0;
    do_reset();
    obstacle_mask = '0; obstacle_mask[7] = 1'b1; obstacle_mask[13] = 1'b1;
    goal_state = 6'd24;
    do_start(0);
    do_step(1, 3, t);
    en = 1'b0; act_valid = 1'b1; action = 2'd2;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (m_act_ready !== 1'b0 || m_upd_valid !== 1'b0 || m_cur_o !== 6'd1 || m_step_o !== 16'd1 || m_busy !== 1'b1) begin
        failures++;
        $display("FAIL en_low_wait: ready=%b valid=%b cur=%0d step=%0d busy=%b, need 0 0 1 1 1",
                 m_act_ready, m_upd_valid, m_cur_o, m_step_o, m_busy);
      end
    end
    act_valid = 1'b0; en = 1'b1;
    act_valid = 1'b1;
    @(posedge clk); #1 act_valid = 1'b0;
    en = 1'b0; upd_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (m_upd_valid !== 1'b1 || m_next_o !== 6'd6 || m_reward_o !== 16'hFFFF || m_cur_o !== 6'd1 || m_step_o !== 16'd1) begin
        failures++;
        $display("FAIL en_low_update: valid=%b next=%0d rw=%0d cur=%0d step=%0d, need 1 6 -1 1 1",
                 m_upd_valid, m_next_o, $signed(m_reward_o), m_cur_o, m_step_o);
      end
    end
    en = 1'b1;
    @(posedge clk); #1 upd_ready = 1'b0;
    checks++;
    if (m_cur_o !== 6'd6 || m_step_o !== 16'd2 || m_act_ready !== 1'b1) begin
      failures++;
      $display("FAIL en_resume: cur=%0d step=%0d ready=%b, need 6 2 1", m_cur_o, m_step_o, m_act_ready);
    end
  endtask

  task automatic test_config_and_async_reset();
    bit t;
    use_t = 1'b0;
    do_reset();
    obstacle_mask = '0; obstacle_mask[7] = 1'b1; obstacle_mask[13] = 1'b1;
    goal_state = 6'd24;
    do_start(7);
    do_start(25);
    do_start(2);
    do_step(2, 0, t);
    do_start(11);
    act_valid = 1'b1; action = 2'd1;
    @(posedge clk); #1 act_valid = 1'b0;
    checks++;
    if (m_upd_valid !== 1'b1 || m_next_o !== 6'd12 || m_epi_o !== 16'd1) begin
      failures++;
      $display("FAIL pre_reset_update: valid=%b next=%0d epi=%0d, need 1 12 1", m_upd_valid, m_next_o, m_epi_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_act_ready, m_upd_valid, m_terminal, m_busy, m_goal, m_error, m_timeout, m_cfg} !== 8'h00 ||
        m_cur_o !== 6'd0 || m_next_o !== 6'd0 || m_reward_o !== 16'd0 || m_step_o !== 16'd0 || m_epi_o !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: bits=%b cur=%0d next=%0d rw=%0d step=%0d epi=%0d, need all 0",
               {m_act_ready, m_upd_valid, m_terminal, m_busy, m_goal, m_error, m_timeout, m_cfg},
               m_cur_o, m_next_o, m_reward_o, m_step_o, m_epi_o);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit t;
    use_t = 1'b0;
    do_reset();
    for (int e = 0; e < 12; e++) begin
      for (int i = 0; i < NC; i++) obstacle_mask[i] = ($urandom_range(0, 4) == 0);
      goal_state = 6'($urandom_range(0, NC - 1));
      do_start($urandom_range(0, 31));
      if (ex_busy) begin
        t = 1'b0;
        for (int s = 0; s < 16 && !t; s++) do_step($urandom_range(0, 3), $urandom_range(0, 2), t);
        if (!t) do_reset();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_goal_path();
    test_wall_and_obstacle();
    test_timeout();
    test_enable();
    test_config_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
